// File: rtl/vedic_seq_mult.sv
// Sequential Urdhva-Tiryagbhyam multiplier: one partial-product column per clock, carry kept between columns.
// Optional build macro VEDIC_SEQ_EARLY_EXIT_EN: a zero operand skips straight to DONE.
module vedic_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(2*WIDTH);
  localparam int KW = $clog2(WIDTH) + 1;
  localparam int SW = $clog2(WIDTH) + 2;
  localparam logic [CW-1:0] LAST_COL = CW'(2*WIDTH - 2);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]    col;
  logic [KW-1:0]    carry;
  logic [SW-1:0]    colsum;
  logic             last_col;

  assign last_col = (col == LAST_COL);

  // Column sum: every a_r[i] & b_r[j] with i+j == col, plus the carry from the previous column.
  always_comb begin
    colsum = SW'(carry);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      for (int unsigned j = 0; j < WIDTH; j++) begin
        if (CW'(i + j) == col)
          colsum = colsum + SW'(a_r[i] & b_r[j]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
`ifdef VEDIC_SEQ_EARLY_EXIT_EN
          if ((a == '0) || (b == '0)) state_next = DONE;
          else                        state_next = COMPUTE;
`else
          state_next = COMPUTE;
`endif
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_col) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      col     <= '0;
      carry   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            col     <= '0;
            carry   <= '0;
            product <= '0;
          end
        end
        COMPUTE: begin
          product[col] <= colsum[0];
          carry        <= colsum[SW-1:1];
          // Top product bit is bit 0 of the carry leaving the last column.
          if (last_col) product[2*WIDTH-1] <= colsum[1];
          else          col <= col + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
